// File: rtl/sram_bridge.sv
// Memory-port responder driving an asynchronous 16-bit SRAM with programmable read/write wait states.
// Optional one-entry write-through read cache enabled by defining SRAM_BRIDGE_RDCACHE_EN.
module sram_bridge #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int WAIT_RD = 2,
  parameter int WAIT_WR = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              wren,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [1:0]        state_dbg
);

  // Handshake: req is held with wren/addr/wdata until ack; ack is a one-cycle pulse,
  // and req is sampled only in IDLE, so a req still high on the edge after ack starts a new access.
  typedef enum logic [1:0] {IDLE, READ, WRITE, WR_RECOVER} state_t;

  localparam int WAIT_MAX = (WAIT_RD > WAIT_WR) ? WAIT_RD : WAIT_WR;
  localparam int CNT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               cache_hit;

`ifdef SRAM_BRIDGE_RDCACHE_EN
  logic               c_valid;
  logic [ADDR_W-1:0]  c_tag;
  logic [DATA_W-1:0]  c_data;
  assign cache_hit = !wren && c_valid && (c_tag == addr);
`else
  assign cache_hit = 1'b0;
`endif

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rdata       <= '0;
      ack         <= 1'b0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
`ifdef SRAM_BRIDGE_RDCACHE_EN
      c_valid     <= 1'b0;
      c_tag       <= '0;
      c_data      <= '0;
`endif
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (cache_hit) begin
`ifdef SRAM_BRIDGE_RDCACHE_EN
              rdata <= c_data;
`endif
              ack   <= 1'b1;
            end else if (wren) begin
              sram_addr   <= addr;
              sram_dq_out <= wdata;
              sram_dq_oe  <= 1'b1;
              sram_ce_n   <= 1'b0;
              sram_we_n   <= 1'b0;
              cnt         <= CNT_W'(WAIT_WR - 1);
              state       <= WRITE;
`ifdef SRAM_BRIDGE_RDCACHE_EN
              if (c_valid && (c_tag == addr)) c_data <= wdata;
`endif
            end else begin
              sram_addr <= addr;
              sram_ce_n <= 1'b0;
              sram_oe_n <= 1'b0;
              cnt       <= CNT_W'(WAIT_RD - 1);
              state     <= READ;
            end
          end
        end
        READ: begin
          if (cnt == '0) begin
            rdata     <= sram_dq_in;
            ack       <= 1'b1;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            state     <= IDLE;
`ifdef SRAM_BRIDGE_RDCACHE_EN
            c_valid   <= 1'b1;
            c_tag     <= sram_addr;
            c_data    <= sram_dq_in;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WRITE: begin
          if (cnt == '0) begin
            sram_we_n <= 1'b1;
            state     <= WR_RECOVER;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WR_RECOVER: begin
          // Data stays driven one cycle past the we_n rise for SRAM hold time.
          sram_ce_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
          ack        <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
